// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder slice: the default operand
// width and the controller state encoding used by serial_adder.
package serial_adder_pkg;

  // Operand/result width used when the parent does not override N
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: waiting, shifting bits through the adder, result valid
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

endpackage

// File: rtl/serial_adder_full_adder.sv
// fullAdder
// Single-bit full adder, the only arithmetic element of the serial adder.
// Ports:
//   a, b  - operand bits
//   cin   - carry in
//   s     - sum bit
//   cout  - carry out
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Classic sum/majority equations
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Adds two N-bit operands plus a carry in, one bit per clock, LSB first,
// using a single full adder and a carry flip-flop. An operation takes
// exactly N rising edges after the edge that accepts start; done then
// pulses for one cycle with z, c and v valid. Results hold until the next
// completed operation.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst   - synchronous active-high reset
//   start - operation request, accepted in IDLE or DONE, ignored in RUN
//   x, y  - N-bit operands, sampled only on an accepted start
//   cIn   - carry in, sampled only on an accepted start
//   busy  - high while bits are being processed
//   done  - one-cycle pulse marking z, c, v valid
//   z     - sum modulo 2^N
//   c     - carry out of the MSB (unsigned overflow)
//   v     - two's-complement overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cIn,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z,
  output logic         c,
  output logic         v
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  stateT         state;
  logic [N-1:0]  xReg;
  logic [N-1:0]  yReg;
  logic [N-1:0]  zShift;
  logic [N-1:0]  zNext;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          sum;
  logic          cout;

  // The current bit of each operand always sits at bit 0 of its shift register
  fullAdder adder (
    .a   (xReg[0]),
    .b   (yReg[0]),
    .cin (carry),
    .s   (sum),
    .cout(cout)
  );

  // New sum bit enters from the MSB side, so after N shifts bit 0 holds the
  // first (LSB) sum bit and the word is in natural order
  assign zNext = (zShift >> 1) | ({{(N-1){1'b0}}, sum} << (N - 1));

  // Controller and datapath in one block. busy/done are registered alongside
  // the state so they are glitch-free. A start seen in DONE is handled like
  // one seen in IDLE so operations can run back to back. The counter stops
  // at N-1 on the final bit rather than wrapping. The overflow flag compares
  // the carry into the MSB (still in the carry register) with the carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      c      <= 1'b0;
      v      <= 1'b0;
      cnt    <= '0;
      xReg   <= '0;
      yReg   <= '0;
      zShift <= '0;
      carry  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xReg   <= x;
            yReg   <= y;
            carry  <= cIn;
            zShift <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          xReg   <= xReg >> 1;
          yReg   <= yReg >> 1;
          carry  <= cout;
          zShift <= zNext;
          if (cnt == LAST) begin
            z     <= zNext;
            c     <= cout;
            v     <= carry ^ cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Directed bench for serial_adder (N=8) with hand-computed expected sums.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] x;
  logic [7:0] y;
  logic       cIn;
  logic       busy;
  logic       done;
  logic [7:0] z;
  logic       c;
  logic       v;

  int checks;
  int errors;
  int lat;
  int busyCnt;
  int doneCnt;

  serial_adder #(.N(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x),
    .y    (y),
    .cIn  (cIn),
    .busy (busy),
    .done (done),
    .z    (z),
    .c    (c),
    .v    (v)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Presents operands with start for exactly one edge; returns #1 after it
  task automatic applyStimulus(input logic [7:0] xv, input logic [7:0] yv,
                               input logic cv);
    x     = xv;
    y     = yv;
    cIn   = cv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done (bounded) and busy cycles seen on the way
  task automatic waitDone(output int edges, output int busyCycles);
    edges      = 0;
    busyCycles = busy ? 1 : 0;
    while (edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
      if (busy) busyCycles++;
    end
  endtask

  // Checks result fields of a completed operation
  task automatic checkResult(input string tag, input logic [7:0] ez,
                             input logic ec, input logic ev);
    checkOutput({tag, "_z"}, 32'(z), 32'(ez));
    checkOutput({tag, "_c"}, 32'(c), 32'(ec));
    checkOutput({tag, "_v"}, 32'(v), 32'(ev));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b1;
    x      = 8'd0;
    y      = 8'd0;
    cIn    = 1'b0;

    // Reset overrides start
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkResult("rst", 8'd0, 1'b0, 1'b0);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;

    // 51 + 12: latency, busy length and single-cycle done
    applyStimulus(8'd51, 8'd12, 1'b0);
    waitDone(lat, busyCnt);
    checkOutput("lat_51_12", 32'(lat), 8);
    checkOutput("busy_51_12", 32'(busyCnt), 8);
    checkResult("add_51_12", 8'd63, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("done_pulse", 32'(done), 0);
    checkOutput("idle_busy", 32'(busy), 0);
    checkResult("hold_51_12", 8'd63, 1'b0, 1'b0);

    // Carry in
    applyStimulus(8'd12, 8'd10, 1'b1);
    waitDone(lat, busyCnt);
    checkOutput("lat_12_10", 32'(lat), 8);
    checkResult("add_12_10_1", 8'd23, 1'b0, 1'b0);

    // Signed overflow without carry, then carry without signed overflow
    applyStimulus(8'd127, 8'd1, 1'b0);
    waitDone(lat, busyCnt);
    checkResult("add_127_1", 8'b1000_0000, 1'b0, 1'b1);
    applyStimulus(8'd255, 8'd1, 1'b0);
    waitDone(lat, busyCnt);
    checkResult("add_255_1", 8'd0, 1'b1, 1'b0);

    // 128 + 128 with start held: back-to-back operations every 9 edges
    x     = 8'd128;
    y     = 8'd128;
    cIn   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    waitDone(lat, busyCnt);
    checkOutput("lat_b2b", 32'(lat), 8);
    checkResult("add_128_128", 8'd0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      waitDone(lat, busyCnt);
      checkOutput("period_b2b", 32'(lat), 9);
      checkResult("b2b", 8'd0, 1'b1, 1'b1);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("b2b_stop_busy", 32'(busy), 0);

    // Start pulsed during RUN with other operands is ignored: 100 + 50
    applyStimulus(8'd100, 8'd50, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    x     = 8'd1;
    y     = 8'd2;
    cIn   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(lat, busyCnt);
    checkOutput("lat_ignore", 32'(lat + 3), 8);
    checkResult("add_100_50", 8'd150, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("ignore_no_restart", 32'(busy), 0);

    // Reset mid-RUN aborts with no done pulse and clears outputs
    applyStimulus(8'd200, 8'd100, 1'b0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_done", 32'(done), 0);
    checkResult("abort", 8'd0, 1'b0, 1'b0);
    doneCnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) doneCnt++;
    end
    checkOutput("abort_no_done", 32'(doneCnt), 0);

    // Fresh operation after abort
    applyStimulus(8'd0, 8'd0, 1'b0);
    waitDone(lat, busyCnt);
    checkOutput("lat_0_0", 32'(lat), 8);
    checkOutput("done_0_0", 32'(done), 1);
    checkResult("add_0_0", 8'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter N, default 8, shall set the operand and result width in bits; legal range is N >= 2.
REQ-002 clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  shall be the reset: synchronous, active-high.
REQ-004 start  input  1  shall be the operation request, sampled each rising edge.
REQ-005 x  input  N  shall be augend, two's complement or unsigned; sampled only on an accepted start.
REQ-006 y  input  N  shall be addend; sampled only on an accepted start.
REQ-007 cIn  input  1  shall be carry in; sampled only on an accepted start.
REQ-008 busy  output  1  shall be high while the operation is in progress (state RUN).
REQ-009 done  output  1  shall be a one-cycle pulse marking z, c and v valid.
REQ-010 z  output  N  shall be the sum x + y + cIn, modulo 2^N.
REQ-011 c  output  1  shall be carry out of the MSB (unsigned overflow).
REQ-012 v  output  1  shall be the two's-complement overflow flag.

Function
REQ-013 The block shall compute the sum bit-serially, LSB first, one bit per clock, using one full-adder stage plus a carry flip-flop.
REQ-014 The FSM shall have states IDLE, RUN and DONE.
REQ-015 IDLE->RUN shall occur when start=1, latching x, y and cIn into shift/carry registers and clearing the bit counter.
REQ-016 In RUN, each edge shall produce the sum bit for index cnt, shift it into the z register from the MSB side, update carry, and increment cnt.
REQ-017 RUN->DONE shall occur on the edge that processes bit N-1; the block shall take exactly N edges after the start edge to produce a result.
REQ-018 done shall be 1 only in DONE (one cycle); DONE->IDLE shall follow unconditionally, unless REQ-019 applies.
REQ-019 start=1 in DONE shall be accepted exactly as in IDLE (DONE->RUN), allowing back-to-back operations with no idle gap.
REQ-020 start=1 in RUN shall be ignored; the x, y and cIn inputs shall not affect the operation in flight.
REQ-021 c shall equal the final carry register; v shall equal (carry into bit N-1) XOR (carry out of bit N-1).
REQ-022 z, c and v shall update only on the RUN->DONE edge and shall hold until the next completed operation.
REQ-023 The counter width shall be $clog2(N); it shall never wrap during RUN.

Reset
REQ-024 rst=1 at a rising edge shall force state IDLE, busy=0, done=0, z=0, c=0, v=0 and counter=0, overriding start.
REQ-025 A reset asserted mid-RUN shall abort the operation with no done pulse; the next start shall begin a fresh operation.

Structure
REQ-026 A shared package shall hold the state encoding constants (IDLE, RUN, DONE) and the default width constant.
REQ-027 The single sub-module shall be fullAdder (a, b, cin -> s, cout), instantiated once.

Verification
REQ-028 x=51, y=12, cIn=0 with start for one cycle -> done exactly 8 cycles later; z=63, c=0, v=0; busy high for 8 cycles.
REQ-029 x=12, y=10, cIn=1 -> z=23, c=0, v=0.
REQ-030 x=127, y=1, cIn=0 -> z=8'b10000000, c=0, v=1; then x=255, y=1 -> z=0, c=1, v=0.
REQ-031 x=128, y=128, cIn=0 -> z=0, c=1, v=1; start held high continuously -> a new operation begins in each DONE cycle, so done pulses every 9 cycles.
REQ-032 start is pulsed at cycle 3 of RUN with different operands -> it is ignored; the result equals the original operands' sum.
REQ-033 rst is asserted at cycle 4 of RUN -> no done pulse and all outputs are 0; a subsequent x=0, y=0 operation yields z=0, c=0, v=0.
